// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller.
// No logic; encodings and constants only.
// Not applicable (no handshake).
package branch_redirect_ctrl_pkg;

    // Redirect sequencer states
    typedef enum logic [1:0] {
        BRC_IDLE     = 2'd0,
        BRC_REDIRECT = 2'd1,
        BRC_DRAIN    = 2'd2
    } brc_state_t;

    // Sequential fall-through distance for 32-bit instructions
    localparam int PC_INC = 4;

endpackage

// File: rtl/branch_redirect_ctrl_counter.sv
// Wrapping event counter with synchronous clear.
// Count visible one cycle after the increment strobe.
// No backpressure; clear has priority over increment.
module branch_redirect_ctrl_counter
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear wins over increment; increment wraps modulo 2^W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Detects EX-stage mispredicts, squashes IF/ID and hands the corrected PC to fetch.
// Flush is combinational in the detection cycle; redirect_valid rises one cycle later.
// redirect_valid/redirect_pc hold until fetch_ready; further EX events are ignored while busy.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int N            = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic             ex_taken,
    input  logic             ex_pred_taken,
    input  logic [N-1:0]     ex_pc,
    input  logic [N-1:0]     ex_target,
    input  logic             fetch_ready,
    input  logic             ctr_clear,
    output logic             redirect_valid,
    output logic [N-1:0]     redirect_pc,
    output logic             flush_if,
    output logic             flush_id,
    output logic             busy,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    brc_state_t     state;
    brc_state_t     state_nxt;
    logic [DCW-1:0] drain_cnt;
    logic [DCW-1:0] drain_cnt_nxt;

    logic           br_event;
    logic           eff_taken;
    logic           mispredict;
    logic           take_redirect;
    logic [N-1:0]   correct_pc;

    // Only events seen in IDLE are architectural; anything later is wrong-path
    assign br_event      = ex_valid & (ex_is_branch | ex_is_jump) & (state == BRC_IDLE);
    assign eff_taken     = ex_is_jump | ex_taken;
    assign mispredict    = eff_taken ^ ex_pred_taken;
    assign take_redirect = br_event & mispredict;
    // Fall-through wraps silently at the top of the address space
    assign correct_pc    = eff_taken ? ex_target : (ex_pc + N'(PC_INC));

    assign redirect_valid = (state == BRC_REDIRECT);
    assign busy           = (state != BRC_IDLE);

    // Next-state, drain countdown and flush outputs
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        flush_if      = 1'b0;
        flush_id      = 1'b0;
        case (state)
            BRC_IDLE: begin
                if (take_redirect) begin
                    flush_if  = 1'b1;
                    flush_id  = 1'b1;
                    state_nxt = BRC_REDIRECT;
                end
            end
            BRC_REDIRECT: begin
                flush_if = 1'b1;
                if (fetch_ready) begin
                    state_nxt     = BRC_DRAIN;
                    drain_cnt_nxt = DCW'(DRAIN_CYCLES);
                end
            end
            BRC_DRAIN: begin
                flush_if = 1'b1;
                if (drain_cnt <= DCW'(1)) begin
                    state_nxt     = BRC_IDLE;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt - DCW'(1);
                end
            end
            default: begin
                state_nxt     = BRC_IDLE;
                drain_cnt_nxt = '0;
            end
        endcase
    end

    // State, drain counter and latched redirect target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BRC_IDLE;
            drain_cnt   <= '0;
            redirect_pc <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (take_redirect) begin
                redirect_pc <= correct_pc;
            end
        end
    end

    branch_redirect_ctrl_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clear),
        .inc   (br_event),
        .count (branch_count)
    );

    branch_redirect_ctrl_counter #(.W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clear),
        .inc   (take_redirect),
        .count (mispredict_count)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
// fetch_ready is driven per scenario to exercise handshake stalls.
module tb_branch_redirect_ctrl;

    localparam int N     = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             ex_valid;
    logic             ex_is_branch;
    logic             ex_is_jump;
    logic             ex_taken;
    logic             ex_pred_taken;
    logic [N-1:0]     ex_pc;
    logic [N-1:0]     ex_target;
    logic             fetch_ready;
    logic             ctr_clear;
    logic             redirect_valid;
    logic [N-1:0]     redirect_pc;
    logic             flush_if;
    logic             flush_id;
    logic             busy;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    int n_tests = 0;
    int n_fail  = 0;

    branch_redirect_ctrl #(.N(N), .DRAIN_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jump       (ex_is_jump),
        .ex_taken         (ex_taken),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .fetch_ready      (fetch_ready),
        .ctr_clear        (ctr_clear),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush_if         (flush_if),
        .flush_id         (flush_id),
        .busy             (busy),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns past the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an EX instruction and let combinational outputs settle
    task automatic drive_ex(input logic br, input logic jmp, input logic tk, input logic pred,
                            input logic [N-1:0] pc, input logic [N-1:0] tgt);
        ex_valid      = 1'b1;
        ex_is_branch  = br;
        ex_is_jump    = jmp;
        ex_taken      = tk;
        ex_pred_taken = pred;
        ex_pc         = pc;
        ex_target     = tgt;
        #1;
    endtask

    task automatic clear_ex();
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
        ex_is_jump   = 1'b0;
        ex_taken     = 1'b0;
        #1;
    endtask

    // Bounded wait for the controller to return to IDLE
    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 20) begin
            step();
            k++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, k);
        end
    endtask

    task automatic test_reset();
        // Power-on state
        n_tests++;
        if ({redirect_valid, busy, flush_if, flush_id} !== 4'b0 || redirect_pc !== '0 ||
            branch_count !== '0 || mispredict_count !== '0) begin
            n_fail++;
            $display("FAIL reset_init: rv=%b busy=%b fif=%b fid=%b pc=%h bc=%h mc=%h, required all 0",
                     redirect_valid, busy, flush_if, flush_id, redirect_pc, branch_count, mispredict_count);
        end
        // Get stuck in REDIRECT, then reset asynchronously
        fetch_ready = 1'b0;
        drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0080);
        step();
        clear_ex();
        step();
        n_tests++;
        if (redirect_valid !== 1'b1 || mispredict_count !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_pre: rv=%b mc=%h, required 1 and 0001", redirect_valid, mispredict_count);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({redirect_valid, busy, flush_if, flush_id} !== 4'b0 || redirect_pc !== '0 ||
            branch_count !== '0 || mispredict_count !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_redirect: rv=%b busy=%b fif=%b fid=%b pc=%h bc=%h mc=%h, required all 0",
                     redirect_valid, busy, flush_if, flush_id, redirect_pc, branch_count, mispredict_count);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_beq_mispredict();
        int bcyc;
        fetch_ready = 1'b1;
        drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0080);
        n_tests++;
        if (flush_if !== 1'b1 || flush_id !== 1'b1 || redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_detect: fif=%b fid=%b rv=%b, required 1 1 0", flush_if, flush_id, redirect_valid);
        end
        step();
        clear_ex();
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0080 || flush_id !== 1'b0 || flush_if !== 1'b1) begin
            n_fail++;
            $display("FAIL beq_redirect: rv=%b pc=%h fid=%b fif=%b, required 1 00000080 0 1",
                     redirect_valid, redirect_pc, flush_id, flush_if);
        end
        bcyc = 0;
        while (busy === 1'b1 && bcyc < 20) begin
            bcyc++;
            step();
        end
        n_tests++;
        if (bcyc != 3) begin
            n_fail++;
            $display("FAIL beq_busy_len: busy for %0d cycles, required 3", bcyc);
        end
        n_tests++;
        if (mispredict_count !== 16'd1 || branch_count !== 16'd1 || flush_if !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_counts: mc=%h bc=%h fif=%b, required 0001 0001 0", mispredict_count, branch_count, flush_if);
        end
    endtask

    task automatic test_bne_stall();
        fetch_ready = 1'b0;
        drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0999);
        step();
        clear_ex();
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin
                fetch_ready = 1'b1;
                #1;
            end
            n_tests++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0204) begin
                n_fail++;
                $display("FAIL bne_stall_c%0d: rv=%b pc=%h, required 1 00000204", c, redirect_valid, redirect_pc);
            end
            step();
        end
        n_tests++;
        if (redirect_valid !== 1'b0 || flush_if !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bne_drain: rv=%b fif=%b busy=%b, required 0 1 1", redirect_valid, flush_if, busy);
        end
        // A mispredict arriving during drain is wrong-path and must be ignored
        drive_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0600);
        n_tests++;
        if (flush_id !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_ignore_flush: fid=%b, required 0", flush_id);
        end
        step();
        clear_ex();
        wait_idle("bne_idle");
        n_tests++;
        if (branch_count !== 16'd2 || mispredict_count !== 16'd2 || redirect_pc !== 32'h0000_0204) begin
            n_fail++;
            $display("FAIL drain_ignore_count: bc=%h mc=%h pc=%h, required 0002 0002 00000204",
                     branch_count, mispredict_count, redirect_pc);
        end
    endtask

    task automatic test_correct_predict();
        fetch_ready = 1'b1;
        drive_ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0340);
        n_tests++;
        if (flush_if !== 1'b0 || flush_id !== 1'b0) begin
            n_fail++;
            $display("FAIL pred_ok_flush: fif=%b fid=%b, required 0 0", flush_if, flush_id);
        end
        step();
        clear_ex();
        n_tests++;
        if (redirect_valid !== 1'b0 || busy !== 1'b0 || branch_count !== 16'd3 || mispredict_count !== 16'd2) begin
            n_fail++;
            $display("FAIL pred_ok_state: rv=%b busy=%b bc=%h mc=%h, required 0 0 0003 0002",
                     redirect_valid, busy, branch_count, mispredict_count);
        end
    endtask

    task automatic test_pc_wrap();
        fetch_ready = 1'b1;
        drive_ex(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0010);
        step();
        clear_ex();
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0010) begin
            n_fail++;
            $display("FAIL jal_target: rv=%b pc=%h, required 1 00000010", redirect_valid, redirect_pc);
        end
        wait_idle("jal_idle");
        drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_1234);
        step();
        clear_ex();
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL pc_wrap: rv=%b pc=%h, required 1 00000000", redirect_valid, redirect_pc);
        end
        wait_idle("wrap_idle");
        n_tests++;
        if (branch_count !== 16'd5 || mispredict_count !== 16'd4) begin
            n_fail++;
            $display("FAIL wrap_counts: bc=%h mc=%h, required 0005 0004", branch_count, mispredict_count);
        end
    endtask

    task automatic test_back_to_back_counters();
        fetch_ready = 1'b1;
        ctr_clear = 1'b1;
        step();
        ctr_clear = 1'b0;
        #1;
        // Correctly predicted branches every cycle keep the controller in IDLE
        drive_ex(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0440);
        repeat (65535) @(posedge clk);
        #1;
        clear_ex();
        n_tests++;
        if (branch_count !== 16'hFFFF || mispredict_count !== 16'h0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ctr_full: bc=%h mc=%h busy=%b, required FFFF 0000 0", branch_count, mispredict_count, busy);
        end
        drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0440);
        step();
        clear_ex();
        n_tests++;
        if (branch_count !== 16'h0000 || mispredict_count !== 16'h0001) begin
            n_fail++;
            $display("FAIL ctr_wrap: bc=%h mc=%h, required 0000 0001", branch_count, mispredict_count);
        end
        wait_idle("ctr_idle");
        // Clear and mispredict event in the same cycle: clear wins
        ctr_clear = 1'b1;
        drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0700, 32'h0000_0800);
        step();
        ctr_clear = 1'b0;
        clear_ex();
        n_tests++;
        if (branch_count !== 16'h0000 || mispredict_count !== 16'h0000 || redirect_pc !== 32'h0000_0704) begin
            n_fail++;
            $display("FAIL ctr_clear_wins: bc=%h mc=%h pc=%h, required 0000 0000 00000704",
                     branch_count, mispredict_count, redirect_pc);
        end
        wait_idle("clear_idle");
    endtask

    initial begin
        rst_n         = 1'b0;
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_is_jump    = 1'b0;
        ex_taken      = 1'b0;
        ex_pred_taken = 1'b0;
        ex_pc         = '0;
        ex_target     = '0;
        fetch_ready   = 1'b0;
        ctr_clear     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        test_reset();
        test_beq_mispredict();
        test_bne_stall();
        test_correct_predict();
        test_pc_wrap();
        test_back_to_back_counters();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences control-flow redirects for the core. It takes the branch decision resolved in EX (the `branch` output of the branch controller plus jump/prediction info), decides whether fetch went down the wrong path, squashes IF/ID, and hands the corrected PC to the fetch unit over a valid/ready handshake. It sits between the EX stage and the PC/fetch unit and also keeps branch and mispredict counters for performance reporting.

## Interface
Parameters:
- `N`, 32, address/data bus width
- `DRAIN_CYCLES`, 2, cycles of continued IF squash after fetch accepts a redirect (≥1)
- `CNT_W`, 16, width of the performance counters

Ports:
- `clk`  in  1  core clock; all state changes on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  EX holds a valid instruction this cycle
- `ex_is_branch`  in  1  EX instruction is a conditional branch
- `ex_is_jump`  in  1  EX instruction is JAL/JALR
- `ex_taken`  in  1  resolved branch condition from the branch controller
- `ex_pred_taken`  in  1  direction fetch predicted for this instruction
- `ex_pc`  in  N  PC of the EX instruction
- `ex_target`  in  N  computed branch/jump target
- `fetch_ready`  in  1  fetch accepts the redirect this cycle
- `ctr_clear`  in  1  synchronous clear of both counters
- `redirect_valid`  out  1  `redirect_pc` is valid
- `redirect_pc`  out  N  corrected next PC
- `flush_if`  out  1  squash instruction in IF/ID register
- `flush_id`  out  1  squash instruction in ID/EX register
- `busy`  out  1  state ≠ IDLE
- `branch_count`  out  CNT_W  resolved branches + jumps
- `mispredict_count`  out  CNT_W  redirects issued

## Operation
- Event: `ex_valid & (ex_is_branch | ex_is_jump)` while state = IDLE.
- Effective taken = `ex_is_jump | ex_taken`. Mispredict = effective taken ≠ `ex_pred_taken` (jumps with `ex_pred_taken`=0 always mispredict).
- Correct PC = effective taken ? `ex_target` : `ex_pc + 4` (modulo 2^N, wraps silently).
- FSM states: IDLE, REDIRECT, DRAIN.
  - IDLE → REDIRECT on event with mispredict; correct PC latched into `redirect_pc`.
  - REDIRECT: `redirect_valid`=1, `flush_if`=1; `redirect_pc` stable. → DRAIN on `fetch_ready`=1.
  - DRAIN: `flush_if`=1 for exactly `DRAIN_CYCLES` cycles (down-counter), then → IDLE.
- `flush_if` and `flush_id` are combinational in IDLE: both 1 in the detection cycle. `flush_id`=0 in REDIRECT/DRAIN.
- Events while not IDLE are ignored (wrong-path, already flushed); not counted.
- `branch_count` +1 per event in IDLE; `mispredict_count` +1 per mispredicting event. Both wrap at 2^CNT_W. `ctr_clear` wins over increment in the same cycle.

## Timing
- Reset (async, any state): state=IDLE, `redirect_valid`=0, `redirect_pc`=0, `busy`=0, counters=0, drain counter=0; `flush_*` 0 unless driven by a same-cycle event after release.
- Detection cycle T: `flush_if`/`flush_id`=1 combinationally; `redirect_valid`=1 from T+1.
- Handshake: transfer when `redirect_valid & fetch_ready` at a rising edge; `redirect_valid` drops the next cycle. `fetch_ready` held high → REDIRECT lasts exactly 1 cycle.
- Total redirect penalty with `fetch_ready` always 1: 1 + DRAIN_CYCLES cycles of `busy`.
- Correctly predicted event: counters update at T+1 edge, no flush, stays IDLE.
- Reset asserted in REDIRECT: redirect is dropped; fetch sees `redirect_valid` fall with no transfer (legal).

## Structure
- Shared package/header: FSM state encodings (`BRC_IDLE`, `BRC_REDIRECT`, `BRC_DRAIN`), the PC increment constant 4; reuse the existing instruction/funct define headers.
- No sub-module required; counters may use one small `sat_wrap_counter` sub-module instantiated twice.

## Test plan
- Reset mid-REDIRECT (`fetch_ready`=0): deassert `rst_n` → all outputs 0, `busy`=0 immediately, counters 0.
- BEQ, `ex_taken`=1, pred=0, pc=0x100, target=0x80, `fetch_ready`=1 → flush_if/id at T, `redirect_pc`=0x80 at T+1, `busy` 3 cycles, mispredict_count=1.
- BNE, `ex_taken`=0, pred=1, pc=0x200 → `redirect_pc`=0x204; `fetch_ready` low 4 cycles → `redirect_valid` and pc stable 5 cycles.
- Branch taken, pred=1 → no flush, no redirect, branch_count=1, mispredict_count=0.
- JAL at pc=0xFFFFFFFC, pred=0, target=0x10 → `redirect_pc`=0x10; branch not-taken mispredict at 0xFFFFFFFC → `redirect_pc`=0x0 (wrap).
- Counters at 0xFFFF + event → 0x0000; `ctr_clear` together with event → both 0.
